// File: rtl/count_order_load_final.sv
// Up/down counter with synchronous parallel load and synchronous active-high reset.
// Optional saturation at the limits when COUNT_ORDER_LOAD_SAT_EN is defined; wraps otherwise.
module count_order_load_final #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] vf,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;

    // Load beats counting; dir only matters when the counter advances.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = vf;
        end else if (!dir) begin
`ifdef COUNT_ORDER_LOAD_SAT_EN
            cnt_nxt = (cnt == MAXV) ? cnt : cnt + ONE;
`else
            cnt_nxt = cnt + ONE;
`endif
        end else begin
`ifdef COUNT_ORDER_LOAD_SAT_EN
            cnt_nxt = (cnt == '0) ? cnt : cnt - ONE;
`else
            cnt_nxt = cnt - ONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

    assign out = cnt;

endmodule

// File: tb/tb_count_order_load_final.sv
// Self-checking bench for count_order_load_final: directed scenarios plus a randomized
// run against an integer reference model (honours COUNT_ORDER_LOAD_SAT_EN).
module tb_count_order_load_final;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, dir, load;
    logic [W-1:0] vf;
    logic [W-1:0] out;

    int n_cmp = 0;
    int n_bad = 0;

    count_order_load_final #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .dir (dir),
        .load(load),
        .vf  (vf),
        .out (out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: next count from the priority rules, plain integer arithmetic.
    function automatic int ref_next(int c, bit r, bit l, bit d, int v);
        if (r) return 0;
        if (l) return v;
`ifdef COUNT_ORDER_LOAD_SAT_EN
        if (!d) return (c == MAXV) ? MAXV : c + 1;
        return (c == 0) ? 0 : c - 1;
`else
        if (!d) return (c + 1) % (MAXV + 1);
        return (c + MAXV) % (MAXV + 1);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'($urandom); dir = 1'($urandom); vf = W'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_edge%0d: got %h expected 0", i, out);
            end
        end
        rst = 1'b1; load = 1'b1; vf = 4'h9;
        tick();
        n_cmp++;
        if (out !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_over_load: got %h expected 0", out);
        end
    endtask

    task automatic test_load();
        logic [W-1:0] exp [3];
        exp = '{4'hA, 4'hB, 4'hC};
        rst = 1'b0; load = 1'b1; vf = 4'h9; dir = 1'b1;
        tick();
        n_cmp++;
        if (out !== 4'h9) begin
            n_bad++;
            $display("FAIL load_value: got %h expected 9", out);
        end
        load = 1'b0; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out !== exp[i]) begin
                n_bad++;
                $display("FAIL load_then_up%0d: got %h expected %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_load_held();
        logic [W-1:0] v;
        rst = 1'b0; load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = W'($urandom); vf = v; dir = 1'($urandom);
            tick();
            n_cmp++;
            if (out !== v) begin
                n_bad++;
                $display("FAIL load_held%0d: got %h expected %h", i, out, v);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] exp [3];
`ifdef COUNT_ORDER_LOAD_SAT_EN
        exp = '{4'hF, 4'hF, 4'hF};
`else
        exp = '{4'hF, 4'h0, 4'h1};
`endif
        rst = 1'b0; load = 1'b1; vf = 4'hE;
        tick();
        load = 1'b0; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out !== exp[i]) begin
                n_bad++;
                $display("FAIL up_wrap%0d: got %h expected %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [W-1:0] exp [3];
`ifdef COUNT_ORDER_LOAD_SAT_EN
        exp = '{4'h0, 4'h0, 4'h0};
`else
        exp = '{4'h0, 4'hF, 4'hE};
`endif
        rst = 1'b0; load = 1'b1; vf = 4'h1;
        tick();
        load = 1'b0; dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out !== exp[i]) begin
                n_bad++;
                $display("FAIL down_wrap%0d: got %h expected %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_dir_switch();
        logic [W-1:0] exp [4];
        exp = '{4'h6, 4'h7, 4'h6, 4'h5};
        rst = 1'b0; load = 1'b1; vf = 4'h5;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dir = (i >= 2);
            tick();
            n_cmp++;
            if (out !== exp[i]) begin
                n_bad++;
                $display("FAIL dir_switch%0d: got %h expected %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] after;
`ifdef COUNT_ORDER_LOAD_SAT_EN
        after = 4'h0;
`else
        after = 4'hF;
`endif
        rst = 1'b0; load = 1'b1; vf = 4'h6;
        tick();
        load = 1'b0; dir = 1'b0;
        tick();
        n_cmp++;
        if (out !== 4'h7) begin
            n_bad++;
            $display("FAIL mid_count_pre: got %h expected 7", out);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (out !== 4'h0) begin
            n_bad++;
            $display("FAIL mid_count_reset: got %h expected 0", out);
        end
        rst = 1'b0; dir = 1'b1;
        tick();
        n_cmp++;
        if (out !== after) begin
            n_bad++;
            $display("FAIL mid_count_resume: got %h expected %h", out, after);
        end
    endtask

    task automatic test_random();
        int model;
        rst = 1'b1; load = 1'b0; dir = 1'b0;
        tick();
        model = 0;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 19) == 0);
            load = ($urandom_range(0, 5) == 0);
            dir  = 1'($urandom);
            vf   = W'($urandom);
            // Occasionally park at a limit so saturation/wrap edges get exercised.
            if ($urandom_range(0, 9) == 0) begin
                load = 1'b1;
                vf   = $urandom_range(0, 1) ? W'(MAXV) : '0;
            end
            model = ref_next(model, rst, load, dir, int'(vf));
            tick();
            n_cmp++;
            if (out !== W'(model)) begin
                n_bad++;
                $display("FAIL random%0d: got %h expected %h", i, out, W'(model));
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; dir = 1'b0; vf = '0;
        #2;
        test_reset();
        test_load();
        test_load_held();
        test_up_wrap();
        test_down_wrap();
        test_dir_switch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
